// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: lets two requesters share one external combinational ALU.
// It grants one requester, registers its operands, captures the ALU result
// one cycle later, and holds that result until the consumer takes it.
module alu_share_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [1:0] req_mode,
  input  logic [5:0] req_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_mode,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_out,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_cout,
  output logic [7:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] grant;
  logic       grantIdx;
  logic       accept;
  logic       lastGrant_q;
  logic       owner_q;
  logic [3:0] opA_q, opB_q;
  logic       opMode_q;
  logic [2:0] opOp_q;
  logic       rspId_q;
  logic [3:0] rspData_q;
  logic       rspCout_q;
  logic [7:0] doneCnt_q;

  // Arbitration: a lone requester always wins; on contention round-robin
  // picks whoever did not win last time, fixed priority picks requester 0.
  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = (RR_EN && !lastGrant_q) ? 2'b10 : 2'b01;
    end else begin
      grant = req_valid;
    end
  end

  assign grantIdx = grant[1];
  assign accept   = (state_q == IDLE) && (req_valid != 2'b00);

  // State register; reset drops any in-flight operation back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; EXEC is always a single cycle and any unused
  // encoding falls back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = accept ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state; ready is also masked while in reset.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    if ((state_q == IDLE) && rst_n) begin
      req_ready = grant;
    end
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
    end
  end

  // Operand capture on acceptance; the ALU only ever sees these registers,
  // so they stay frozen through EXEC and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA_q       <= 4'd0;
      opB_q       <= 4'd0;
      opMode_q    <= 1'b0;
      opOp_q      <= 3'd0;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
    end else if (accept) begin
      opA_q       <= grantIdx ? req_a[7:4] : req_a[3:0];
      opB_q       <= grantIdx ? req_b[7:4] : req_b[3:0];
      opMode_q    <= req_mode[grantIdx];
      opOp_q      <= grantIdx ? req_op[5:3] : req_op[2:0];
      owner_q     <= grantIdx;
      lastGrant_q <= grantIdx;
    end
  end

  // Result capture at the end of EXEC; held untouched while RESP stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspId_q   <= 1'b0;
      rspData_q <= 4'd0;
      rspCout_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rspId_q   <= owner_q;
      rspData_q <= alu_out;
      rspCout_q <= alu_cout;
    end
  end

  // Completed-response counter, bumped on each handshake and wrapping at 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doneCnt_q <= 8'd0;
    end else if ((state_q == RESP) && rsp_ready) begin
      doneCnt_q <= doneCnt_q + 8'd1;
    end
  end

  assign alu_a    = opA_q;
  assign alu_b    = opB_q;
  assign alu_mode = opMode_q;
  assign alu_op   = opOp_q;
  assign rsp_id   = rspId_q;
  assign rsp_data = rspData_q;
  assign rsp_cout = rspCout_q;
  assign done_cnt = doneCnt_q;

endmodule
